axi_mem_sub: RTL and testbench



---
 rtl/axi_mem_sub_pkg.sv | 27 ++
 rtl/axi_mem_sub_ram.sv | 31 +++
 rtl/axi_mem_sub.sv | 201 ++++++++++++++++++++
 tb/tb_axi_mem_sub.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_sub_pkg.sv
// Shared encodings and state types for the AXI4 subordinate memory.
package axi_mem_sub_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Only FIXED and INCR are serviced; WRAP and the reserved code get SLVERR.
  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_mem_sub_ram.sv
// Byte-enabled register array: one synchronous write port, one asynchronous read port.
module axi_mem_sub_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb[i]) begin
          mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read is combinational so a read beat loaded at an edge sees pre-write contents.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_sub.sv
// AXI4 subordinate memory: one outstanding write and one outstanding read,
// INCR/FIXED bursts into an internal byte-enabled array, WRAP rejected with SLVERR.
module axi_mem_sub #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast
);

  import axi_mem_sub_pkg::*;

  localparam int ADDR_LSB = $clog2(AXI_STRB_WIDTH);

  wr_state_t                 w_state_reg;
  logic [MEM_DEPTH_LOG2-1:0] w_index_reg;
  logic [7:0]                w_len_reg;
  logic [8:0]                w_count_reg;
  logic [1:0]                w_burst_reg;

  rd_state_t                 r_state_reg;
  logic [MEM_DEPTH_LOG2-1:0] r_index_reg;
  logic [7:0]                r_len_reg;
  logic [7:0]                r_count_reg;
  logic [1:0]                r_burst_reg;

  logic [MEM_DEPTH_LOG2-1:0] aw_index;
  logic [MEM_DEPTH_LOG2-1:0] ar_index;
  logic [MEM_DEPTH_LOG2-1:0] rd_addr;
  logic                      mem_we;
  logic [AXI_DATA_WIDTH-1:0] mem_rdata;
  logic                      unused_inputs;

  assign aw_index = s_axi_awaddr[ADDR_LSB +: MEM_DEPTH_LOG2];
  assign ar_index = s_axi_araddr[ADDR_LSB +: MEM_DEPTH_LOG2];

  // Size fields and out-of-range address bits carry no information for this memory.
  assign unused_inputs = ^{s_axi_awsize, s_axi_arsize, s_axi_awaddr, s_axi_araddr};

  assign mem_we = (w_state_reg == W_DATA) && s_axi_wready && s_axi_wvalid
                  && burst_ok(w_burst_reg);

  // In idle the read port looks at the incoming AR address so beat 0 is ready at the handshake.
  assign rd_addr = (r_state_reg == R_IDLE) ? ar_index : r_index_reg;

  axi_mem_sub_ram #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .STRB_WIDTH (AXI_STRB_WIDTH),
    .DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_index_reg),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_reg   <= W_IDLE;
      w_index_reg   <= '0;
      w_len_reg     <= '0;
      w_count_reg   <= '0;
      w_burst_reg   <= BURST_INCR;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (s_axi_awready && s_axi_awvalid) begin
            w_index_reg   <= aw_index;
            w_len_reg     <= s_axi_awlen;
            w_burst_reg   <= s_axi_awburst;
            w_count_reg   <= '0;
            s_axi_bid     <= s_axi_awid;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state_reg   <= W_DATA;
          end else begin
            s_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (s_axi_wready && s_axi_wvalid) begin
            if (w_burst_reg == BURST_INCR) begin
              w_index_reg <= w_index_reg + 1'b1;
            end
            w_count_reg <= w_count_reg + 9'd1;
            if (s_axi_wlast) begin
              // wlast defines the burst length; disagreement with awlen is reported.
              s_axi_bresp  <= (!burst_ok(w_burst_reg) || (w_count_reg != {1'b0, w_len_reg}))
                              ? RESP_SLVERR : RESP_OKAY;
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              w_state_reg  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            w_state_reg  <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_reg   <= R_IDLE;
      r_index_reg   <= '0;
      r_len_reg     <= '0;
      r_count_reg   <= '0;
      r_burst_reg   <= BURST_INCR;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rlast   <= 1'b0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (s_axi_arready && s_axi_arvalid) begin
            r_len_reg     <= s_axi_arlen;
            r_burst_reg   <= s_axi_arburst;
            r_count_reg   <= '0;
            r_index_reg   <= (s_axi_arburst == BURST_INCR) ? ar_index + 1'b1 : ar_index;
            s_axi_rid     <= s_axi_arid;
            s_axi_rresp   <= burst_ok(s_axi_arburst) ? RESP_OKAY : RESP_SLVERR;
            s_axi_rdata   <= burst_ok(s_axi_arburst) ? mem_rdata : '0;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            r_state_reg   <= R_DATA;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid <= 1'b0;
              s_axi_rlast  <= 1'b0;
              r_state_reg  <= R_IDLE;
            end else begin
              // r_index_reg already points at the beat being loaded here.
              s_axi_rdata <= burst_ok(r_burst_reg) ? mem_rdata : '0;
              s_axi_rlast <= ((r_count_reg + 8'd1) == r_len_reg);
              r_count_reg <= r_count_reg + 8'd1;
              if (r_burst_reg == BURST_INCR) begin
                r_index_reg <= r_index_reg + 1'b1;
              end
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_sub.sv
// Directed and randomized bursts against a word-array reference model of the memory.
module tb_axi_mem_sub;

  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int IW    = 4;
  localparam int SW    = DW / 8;
  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;
  localparam int TMO   = 200;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_axi_awvalid, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr;
  logic [IW-1:0] s_axi_awid;
  logic [7:0]    s_axi_awlen;
  logic [2:0]    s_axi_awsize;
  logic [1:0]    s_axi_awburst;
  logic          s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata;
  logic [SW-1:0] s_axi_wstrb;
  logic          s_axi_wlast;
  logic          s_axi_bvalid, s_axi_bready;
  logic [IW-1:0] s_axi_bid;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_arvalid, s_axi_arready;
  logic [AW-1:0] s_axi_araddr;
  logic [IW-1:0] s_axi_arid;
  logic [7:0]    s_axi_arlen;
  logic [2:0]    s_axi_arsize;
  logic [1:0]    s_axi_arburst;
  logic          s_axi_rvalid, s_axi_rready;
  logic [IW-1:0] s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;

  always #5 clk = ~clk;

  axi_mem_sub #(
    .AXI_ADDR_WIDTH (AW), .AXI_DATA_WIDTH (DW), .AXI_ID_WIDTH (IW),
    .AXI_STRB_WIDTH (SW), .MEM_DEPTH_LOG2 (DL)
  ) dut (
    .clk (clk), .rst (rst),
    .s_axi_awvalid (s_axi_awvalid), .s_axi_awready (s_axi_awready),
    .s_axi_awaddr (s_axi_awaddr), .s_axi_awid (s_axi_awid), .s_axi_awlen (s_axi_awlen),
    .s_axi_awsize (s_axi_awsize), .s_axi_awburst (s_axi_awburst),
    .s_axi_wvalid (s_axi_wvalid), .s_axi_wready (s_axi_wready),
    .s_axi_wdata (s_axi_wdata), .s_axi_wstrb (s_axi_wstrb), .s_axi_wlast (s_axi_wlast),
    .s_axi_bvalid (s_axi_bvalid), .s_axi_bready (s_axi_bready),
    .s_axi_bid (s_axi_bid), .s_axi_bresp (s_axi_bresp),
    .s_axi_arvalid (s_axi_arvalid), .s_axi_arready (s_axi_arready),
    .s_axi_araddr (s_axi_araddr), .s_axi_arid (s_axi_arid), .s_axi_arlen (s_axi_arlen),
    .s_axi_arsize (s_axi_arsize), .s_axi_arburst (s_axi_arburst),
    .s_axi_rvalid (s_axi_rvalid), .s_axi_rready (s_axi_rready),
    .s_axi_rid (s_axi_rid), .s_axi_rdata (s_axi_rdata),
    .s_axi_rresp (s_axi_rresp), .s_axi_rlast (s_axi_rlast)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] wd [256];
  logic [SW-1:0] ws [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed no handshake, expected one within %0d cycles", tag, TMO);
  endtask

  function automatic int word_of(input logic [AW-1:0] addr);
    return (int'(addr) / SW) % DEPTH;
  endfunction

  // Reference write: apply strobed bytes beat by beat, return the expected response.
  function automatic logic [1:0] model_write(input logic [AW-1:0] addr, input logic [7:0] len,
                                             input logic [1:0] burst, input int nbeats);
    int idx;
    bit ok;
    idx = word_of(addr);
    ok  = (burst == FIXED) || (burst == INCR);
    for (int i = 0; i < nbeats; i++) begin
      if (ok) begin
        for (int b = 0; b < SW; b++) begin
          if (ws[i][b]) model_mem[idx][b*8 +: 8] = wd[i][b*8 +: 8];
        end
      end
      if (burst == INCR) idx = (idx + 1) % DEPTH;
    end
    return (!ok || nbeats != int'(len) + 1) ? SLVERR : OKAY;
  endfunction

  task automatic send_aw(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    s_axi_awaddr = addr; s_axi_awid = id; s_axi_awlen = len;
    s_axi_awsize = 3'd1; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout_fail("aw_timeout");
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input int i, input bit last);
    int n;
    s_axi_wvalid = 1'b1; s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = last;
    n = 0;
    while (!s_axi_wready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout_fail("w_timeout");
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                           input logic [7:0] len, input logic [1:0] burst, input int nbeats,
                           output logic [1:0] resp, output logic [IW-1:0] bid_o);
    int n;
    send_aw(addr, id, len, burst);
    for (int i = 0; i < nbeats; i++) send_w(i, i == nbeats - 1);
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout_fail("b_timeout");
    resp = s_axi_bresp; bid_o = s_axi_bid;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  // Write and check the response against the model.
  task automatic do_write(input string tag, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                          input logic [7:0] len, input logic [1:0] burst, input int nbeats);
    logic [1:0]    exp_resp, resp;
    logic [IW-1:0] bidv;
    exp_resp = model_write(addr, len, burst, nbeats);
    axi_write(addr, id, len, burst, nbeats, resp, bidv);
    check({tag, "_bresp"}, 32'(resp), 32'(exp_resp));
    check({tag, "_bid"}, 32'(bidv), 32'(id));
    $display("write %s addr=0x%0h len=%0d burst=%0d bresp=%0d", tag, addr, len, burst, resp);
  endtask

  task automatic axi_read(input string tag, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                          input logic [7:0] len, input logic [1:0] burst, input int stall_beat);
    int n, idx;
    bit ok;
    logic [DW-1:0] exp, hold_data;
    logic          hold_last;
    idx = word_of(addr);
    ok  = (burst == FIXED) || (burst == INCR);
    s_axi_araddr = addr; s_axi_arid = id; s_axi_arlen = len;
    s_axi_arsize = 3'd1; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout_fail({tag, "_ar_timeout"});
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!s_axi_rvalid && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) begin timeout_fail({tag, "_r_timeout"}); break; end
      exp = ok ? model_mem[idx] : '0;
      if (i == stall_beat) begin
        s_axi_rready = 1'b0;
        hold_data = s_axi_rdata; hold_last = s_axi_rlast;
        repeat (3) begin
          @(negedge clk);
          check({tag, "_stall_rvalid"}, 32'(s_axi_rvalid), 32'd1);
          check({tag, "_stall_rdata"}, 32'(s_axi_rdata), 32'(hold_data));
          check({tag, "_stall_rlast"}, 32'(s_axi_rlast), 32'(hold_last));
        end
        s_axi_rready = 1'b1;
      end
      check($sformatf("%s_rdata%0d", tag, i), 32'(s_axi_rdata), 32'(exp));
      check($sformatf("%s_rlast%0d", tag, i), 32'(s_axi_rlast), 32'(i == int'(len)));
      check($sformatf("%s_rresp%0d", tag, i), 32'(s_axi_rresp), 32'(ok ? OKAY : SLVERR));
      check($sformatf("%s_rid%0d", tag, i), 32'(s_axi_rid), 32'(id));
      @(negedge clk);
      if (burst == INCR) idx = (idx + 1) % DEPTH;
    end
    s_axi_rready = 1'b0;
    check({tag, "_no_extra_beat"}, 32'(s_axi_rvalid), 32'd0);
    $display("read  %s addr=0x%0h len=%0d burst=%0d", tag, addr, len, burst);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready_valid"}, 32'({s_axi_awready, s_axi_wready, s_axi_bvalid,
                                      s_axi_arready, s_axi_rvalid}), 32'd0);
    check({tag, "_resp_last"}, 32'({s_axi_bresp, s_axi_rresp, s_axi_rlast}), 32'd0);
    check({tag, "_rdata_ids"}, 32'({s_axi_rdata, s_axi_bid, s_axi_rid}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    logic [7:0]    len;
    logic [1:0]    burst;
    int            sel;

    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0;
    s_axi_awsize = 3'd1; s_axi_awburst = INCR;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0; s_axi_bready = 0;
    s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0;
    s_axi_arsize = 3'd1; s_axi_arburst = INCR; s_axi_rready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'({s_axi_awready, s_axi_arready}), 32'd3);

    // Fill the whole memory so every later read has a known expectation
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = 16'($urandom); ws[i] = '1; end
      do_write($sformatf("fill%0d", k), AW'(k * 512), 4'(k), 8'd255, INCR, 256);
    end

    // Eight 3-beat INCR bursts with data 0xD0..0xE7, then read back
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 3; i++) begin wd[i] = 16'(8'hD0 + b * 3 + i); ws[i] = '1; end
      do_write($sformatf("seq%0d", b), AW'(b * 6), 4'(b), 8'd2, INCR, 3);
    end
    for (int b = 0; b < 8; b++) begin
      axi_read($sformatf("seq%0d", b), AW'(b * 6), 4'(15 - b), 8'd2, INCR, -1);
    end

    // Low-byte-only write to word 5
    wd[0] = 16'hABCD; ws[0] = 2'b01;
    do_write("strb", 20'h0000A, 4'h3, 8'd0, INCR, 1);
    axi_read("strb", 20'h0000A, 4'h4, 8'd0, INCR, -1);

    // Back-pressure mid-burst
    axi_read("stall", 20'h00100, 4'h5, 8'd3, INCR, 1);

    // WRAP write is absorbed without touching memory; WRAP read returns zeros
    wd[0] = 16'h1111; wd[1] = 16'h2222; ws[0] = '1; ws[1] = '1;
    do_write("wrap", 20'h00040, 4'h6, 8'd1, WRAP, 2);
    axi_read("wrap_chk", 20'h00040, 4'h7, 8'd1, INCR, -1);
    axi_read("wrap_rd", 20'h00040, 4'h8, 8'd1, WRAP, -1);
    axi_read("rsvd_rd", 20'h00044, 4'h9, 8'd0, 2'b11, -1);

    // FIXED burst keeps hammering word 7
    for (int i = 0; i < 4; i++) begin wd[i] = 16'(i + 1); ws[i] = '1; end
    do_write("fixed", 20'h0000E, 4'hA, 8'd3, FIXED, 4);
    axi_read("fixed", 20'h0000E, 4'hB, 8'd0, INCR, -1);

    // INCR across the top word wraps to word 0
    wd[0] = 16'h7E7E; wd[1] = 16'h0A0A; ws[0] = '1; ws[1] = '1;
    do_write("topwrap", 20'h007FE, 4'hC, 8'd1, INCR, 2);
    axi_read("topwrap", 20'h00000, 4'hD, 8'd0, INCR, -1);
    axi_read("alias", 20'hF87FE, 4'hE, 8'd1, INCR, -1);

    // Beat count disagreeing with awlen (no strobes, so memory is untouched)
    for (int i = 0; i < 4; i++) begin wd[i] = 16'hFFFF; ws[i] = '0; end
    do_write("short", 20'h00200, 4'h1, 8'd2, INCR, 2);
    do_write("long", 20'h00200, 4'h2, 8'd2, INCR, 4);

    // Randomized traffic
    for (int t = 0; t < 25; t++) begin
      a   = AW'($urandom);
      len = 8'($urandom_range(0, 7));
      sel = $urandom_range(0, 11);
      burst = (sel < 5) ? FIXED : (sel < 10) ? INCR : (sel == 10) ? WRAP : 2'b11;
      for (int i = 0; i <= int'(len); i++) begin wd[i] = 16'($urandom); ws[i] = SW'($urandom); end
      do_write($sformatf("rnd%0d", t), a, 4'($urandom), len, burst, int'(len) + 1);
      axi_read($sformatf("rnd%0d", t), a, 4'($urandom), len,
               (burst == FIXED) ? FIXED : INCR, $urandom_range(0, 9) - 1);
      axi_read($sformatf("rndx%0d", t), AW'($urandom), 4'($urandom), 8'($urandom_range(0, 5)),
               2'($urandom_range(0, 3)), -1);
    end

    // Reset during beat 1 of a 3-beat write
    wd[0] = 16'h5A5A; wd[1] = 16'hA5A5; ws[0] = '1; ws[1] = '1;
    send_aw(20'h00300, 4'h3, 8'd2, INCR);
    send_w(0, 1'b0);
    model_mem[word_of(20'h00300)] = 16'h5A5A;
    s_axi_wvalid = 1'b1; s_axi_wdata = wd[1]; s_axi_wstrb = ws[1];
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("midrst_ready", 32'({s_axi_awready, s_axi_arready}), 32'd3);
    axi_read("midrst_kept", 20'h00300, 4'h4, 8'd2, INCR, -1);
    for (int i = 0; i < 3; i++) begin wd[i] = 16'($urandom); ws[i] = '1; end
    do_write("postrst", 20'h00300, 4'h5, 8'd2, INCR, 3);
    axi_read("postrst", 20'h00300, 4'h6, 8'd2, INCR, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
